// File: rtl/aibio_pvtmon_meas_ctrl.sv
// rtl/aibio_pvtmon_meas_ctrl.sv - PVT monitor ripple-counter measurement sequencer.
// Optional 4-iteration averaging is enabled with `define PVTMON_AVG_EN.
module aibio_pvtmon_meas_ctrl #(
  parameter int CNT_W      = 10,
  parameter int WIN_W      = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] ctr_cnt,
  output logic             ctr_rb,
  output logic             ctr_din,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_data,
  input  logic             meas_ack,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             cap_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_SETTLE, S_CAP_S, S_CAP_C, S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cnt;
  logic [CNT_W-1:0] s1;
  logic [1:0]       mis_cnt;
  logic [CNT_W-1:0] res_q;
  logic             ahi_q, alo_q, err_q;

  logic             cap_eq, cap_last, cap_done, iter_last, fin_err;
  logic [CNT_W-1:0] cap_val, fin_val;

  assign cap_eq   = (ctr_cnt == s1);
  assign cap_last = !cap_eq && (mis_cnt == 2'd3);
  assign cap_done = cap_eq || cap_last;
  assign cap_val  = cap_eq ? s1 : ctr_cnt;

`ifdef PVTMON_AVG_EN
  logic [1:0]       iter;
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] sum_n;
  logic             err_any;

  assign sum_n     = acc + {2'b00, cap_val};
  assign iter_last = (iter == 2'd3);
  assign fin_val   = sum_n[CNT_W+1:2];
  assign fin_err   = err_any | cap_last;
`else
  assign iter_last = 1'b1;
  assign fin_val   = cap_val;
  assign fin_err   = cap_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_CLR;
      S_CLR:    if (cnt == '0) state_n = S_RUN;
      S_RUN:    if (cnt == '0) state_n = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_n = S_CAP_S;
      S_CAP_S:  state_n = S_CAP_C;
      S_CAP_C:  begin
        if (!cap_done)      state_n = S_CAP_S;
        else if (iter_last) state_n = S_DONE;
        else                state_n = S_CLR;
      end
      S_DONE:   if (meas_ack) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs are a registered image of the current state, so every strobe lags the state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      cnt        <= '0;
      s1         <= '0;
      mis_cnt    <= '0;
      res_q      <= '0;
      ahi_q      <= 1'b0;
      alo_q      <= 1'b0;
      err_q      <= 1'b0;
      ctr_rb     <= 1'b0;
      ctr_din    <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      meas_data  <= '0;
      alarm_hi   <= 1'b0;
      alarm_lo   <= 1'b0;
      cap_err    <= 1'b0;
`ifdef PVTMON_AVG_EN
      iter       <= '0;
      acc        <= '0;
      err_any    <= 1'b0;
`endif
    end else begin
      ctr_rb     <= (state == S_RUN) || (state == S_SETTLE) || (state == S_CAP_S) ||
                    (state == S_CAP_C) || (state == S_DONE);
      ctr_din    <= (state == S_RUN);
      busy       <= (state != S_IDLE) && (state != S_DONE);
      meas_valid <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            win_q    <= (win_len == '0) ? WIN_W'(1) : win_len;
            cnt      <= WIN_W'(1);
            alarm_hi <= 1'b0;
            alarm_lo <= 1'b0;
            cap_err  <= 1'b0;
            ahi_q    <= 1'b0;
            alo_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef PVTMON_AVG_EN
            iter     <= '0;
            acc      <= '0;
            err_any  <= 1'b0;
`endif
          end
        end
        S_CLR: begin
          mis_cnt <= '0;
          if (cnt == '0) cnt <= win_q - WIN_W'(1);
          else           cnt <= cnt - WIN_W'(1);
        end
        S_RUN: begin
          if (cnt == '0) cnt <= WIN_W'(SETTLE_CYC - 1);
          else           cnt <= cnt - WIN_W'(1);
        end
        S_SETTLE: cnt <= cnt - WIN_W'(1);
        S_CAP_S:  s1 <= ctr_cnt;
        S_CAP_C: begin
          if (!cap_done) begin
            mis_cnt <= mis_cnt + 2'd1;
          end else if (iter_last) begin
            res_q <= fin_val;
            ahi_q <= (fin_val > thr_hi);
            alo_q <= (fin_val < thr_lo);
            err_q <= fin_err;
          end
`ifdef PVTMON_AVG_EN
          else begin
            acc     <= sum_n;
            err_any <= fin_err;
            iter    <= iter + 2'd1;
            cnt     <= WIN_W'(1);
          end
`endif
        end
        S_DONE: begin
          meas_data <= res_q;
          alarm_hi  <= ahi_q;
          alarm_lo  <= alo_q;
          cap_err   <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule
